wb_mem_responder: RTL and testbench
===================================

WB_MEM_RESPONDER -- requirements
Module: wb_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, bus data width in bits (one cache line).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter ADDR_GRANULARITY, default 8, bits per select lane.
REQ-004 SHALL have parameter MEM_DEPTH, default 10, log2 of stored line count.
REQ-005 SHALL have parameter WAIT_STATES, default 1, extra cycles inserted before ack (0..15).
REQ-006 SHALL have ports: clk  input  1  clock; rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports: wb_adr_i  input  ADDR_WIDTH  byte address; wb_dat_i  input  DATA_WIDTH  write data; wb_dat_o  output  DATA_WIDTH  read data.
REQ-008 SHALL have ports: wb_we_i  input  1  write enable; wb_sel_i  input  DATA_WIDTH/ADDR_GRANULARITY  lane select; wb_stb_i  input  1  strobe; wb_cyc_i  input  1  cycle.
REQ-009 SHALL have ports: wb_ack_o  output  1  normal termination; wb_err_o  output  1  error termination; wb_rty_o  output  1  retry, tied 0.

Function
REQ-010 SHALL implement a Wishbone classic (non-pipelined) responder backed by 2^MEM_DEPTH lines of DATA_WIDTH bits.
REQ-011 SHALL index storage by wb_adr_i[LINE_DEPTH +: MEM_DEPTH], LINE_DEPTH = clog2(DATA_WIDTH/ADDR_GRANULARITY); lower bits ignored.
REQ-012 SHALL use FSM states IDLE, WAIT, RESP; IDLE->WAIT (or RESP when WAIT_STATES=0) on wb_cyc_i & wb_stb_i.
REQ-013 SHALL latch adr, we, sel, dat_i on the IDLE accept edge; later bus changes within the cycle are ignored.
REQ-014 SHALL count WAIT_STATES cycles in WAIT with a down-counter, then enter RESP.
REQ-015 SHALL assert exactly one of wb_ack_o/wb_err_o for exactly one cycle in RESP, i.e. termination appears WAIT_STATES+1 cycles after the accept edge, then return to IDLE.
REQ-016 SHALL on read drive the addressed line on wb_dat_o in the termination cycle and hold it until the next read termination.
REQ-017 SHALL on write update only lanes with wb_sel_i bit set, committed on the termination edge; sel all-zero acks with no change.
REQ-018 SHALL abort to IDLE with no termination and no write if wb_cyc_i drops in WAIT.
REQ-019 SHALL not accept a new request in the RESP cycle; back-to-back requests are separated by at least one IDLE cycle.
REQ-020 SHALL return read data equal to a write to the same line terminated on any earlier cycle (no stale read).

Reset
REQ-021 SHALL on rst force IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, counter=0, immediately and asynchronously.
REQ-022 SHALL on rst mid-transaction discard it: no write committed, no termination after release.
REQ-023 SHALL not clear storage contents on rst.

Configuration
REQ-024 SHALL with WB_RESPONDER_RANGE_CHECK_EN defined: any nonzero wb_adr_i bit above LINE_DEPTH+MEM_DEPTH terminates with wb_err_o, no write, wb_dat_o unchanged.
REQ-025 SHALL without WB_RESPONDER_RANGE_CHECK_EN: upper address bits ignored (aliasing), wb_err_o constant 0.

Structure
REQ-026 SHALL place FSM state enum and LINE_DEPTH/lane-count derivation in shared package wb_pkg.
REQ-027 SHALL place storage in sub-module wb_ram_bank (single-port, per-lane write enable, synchronous read).

Verification
REQ-028 Reset: rst=1 mid-WAIT -> ack/err/dat_o=0 same cycle; no ack after release; line unchanged.
REQ-029 Write/read: WAIT_STATES=1, write 0x0123..CDEF to adr 0x40 sel=0xFFFF -> ack 2 cycles after accept; read 0x40 -> same data, ack 2 cycles later.
REQ-030 Byte lanes: prior line all 0x00, write 0xFF.. with sel=0x0003 -> read returns 0x...0000FFFF.
REQ-031 Abort: cyc dropped in WAIT with WAIT_STATES=3 -> no ack, write not committed.
REQ-032 Range: with macro, adr 0x8000_0000 -> err 1 cycle, ack 0; without macro, same adr -> ack, aliases line 0.
REQ-033 Latency sweep: WAIT_STATES=0 and 15 -> termination exactly 1 and 16 cycles after accept.

Source files
------------

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// | wb_pkg : shared FSM encoding and line geometry helpers for the           |
// |          Wishbone memory responder                                       |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam int unsigned c_CNT_W = 4;

  function automatic int unsigned lane_count(input int unsigned data_width,
                                             input int unsigned granularity);
    return data_width / granularity;
  endfunction

  // Number of byte-address bits that select a lane within one line.
  function automatic int unsigned line_depth(input int unsigned data_width,
                                             input int unsigned granularity);
    return $clog2(data_width / granularity);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_ram_bank.sv
// ---------------------------------------------------------------------------
// | wb_ram_bank : single-port line store, per-lane write enable,             |
// |               synchronous read, contents never cleared                   |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

module wb_ram_bank
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 10
) (
  input  logic                               clk,
  input  logic [ADDR_BITS-1:0]               i_addr,
  input  logic                               i_we,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   i_be,
  input  logic [DATA_WIDTH-1:0]              i_wdata,
  output logic [DATA_WIDTH-1:0]              o_rdata
);

  localparam int unsigned c_LANES = lane_count(DATA_WIDTH, LANE_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int l = 0; l < c_LANES; l++) begin
        if (i_be[l]) begin
          r_mem[i_addr][l*LANE_WIDTH +: LANE_WIDTH] <= i_wdata[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/wb_mem_responder.sv
// ---------------------------------------------------------------------------
// | wb_mem_responder : Wishbone classic responder over a line-wide RAM with  |
// |                    programmable wait states.                             |
// | Optional: WB_RESPONDER_RANGE_CHECK_EN -> out-of-range address gives err  |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

module wb_mem_responder
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 128,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned ADDR_GRANULARITY = 8,
  parameter int unsigned MEM_DEPTH        = 10,
  parameter int unsigned WAIT_STATES      = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [ADDR_WIDTH-1:0]                      wb_adr_i,
  input  logic [DATA_WIDTH-1:0]                      wb_dat_i,
  output logic [DATA_WIDTH-1:0]                      wb_dat_o,
  input  logic                                       wb_we_i,
  input  logic [DATA_WIDTH/ADDR_GRANULARITY-1:0]     wb_sel_i,
  input  logic                                       wb_stb_i,
  input  logic                                       wb_cyc_i,
  output logic                                       wb_ack_o,
  output logic                                       wb_err_o,
  output logic                                       wb_rty_o
);

  localparam int unsigned c_LANES      = lane_count(DATA_WIDTH, ADDR_GRANULARITY);
  localparam int unsigned c_LINE_DEPTH = line_depth(DATA_WIDTH, ADDR_GRANULARITY);
  localparam int unsigned c_TOP        = c_LINE_DEPTH + MEM_DEPTH;
  localparam logic [c_CNT_W-1:0] c_WAIT = c_CNT_W'(WAIT_STATES);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  wb_state_e              r_state;
  wb_state_e              w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_cnt_nxt;

  logic [MEM_DEPTH-1:0]   r_line;
  logic                   r_we;
  logic [c_LANES-1:0]     r_sel;
  logic [DATA_WIDTH-1:0]  r_wdat;
  logic                   r_bad;
  logic [DATA_WIDTH-1:0]  r_dat_hold;

  logic                   w_accept;
  logic                   w_req_bad;
  logic                   w_resp;
  logic                   w_mem_we;
  logic                   w_read_done;
  logic [MEM_DEPTH-1:0]   w_ram_addr;
  logic [DATA_WIDTH-1:0]  w_rdata;
  logic                   w_unused_adr;

  assign w_accept     = (r_state == ST_IDLE) && wb_cyc_i && wb_stb_i;
  assign w_unused_adr = ^wb_adr_i;

`ifdef WB_RESPONDER_RANGE_CHECK_EN
  assign w_req_bad = |(wb_adr_i >> c_TOP);
`else
  assign w_req_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_line     <= '0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_wdat     <= '0;
      r_bad      <= 1'b0;
      r_dat_hold <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_line <= wb_adr_i[c_LINE_DEPTH +: MEM_DEPTH];
        r_we   <= wb_we_i;
        r_sel  <= wb_sel_i;
        r_wdat <= wb_dat_i;
        r_bad  <= w_req_bad;
      end
      if (w_read_done) begin
        r_dat_hold <= w_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_resp      = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = c_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt <= c_ONE) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      ST_RESP: begin
        w_resp      = 1'b1;
        w_mem_we    = r_we && !r_bad;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // In IDLE the RAM looks at the live bus so a zero-wait read has data in RESP.
  assign w_ram_addr  = (r_state == ST_IDLE) ? wb_adr_i[c_LINE_DEPTH +: MEM_DEPTH] : r_line;
  assign w_read_done = w_resp && !r_we && !r_bad;

  wb_ram_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANE_WIDTH (ADDR_GRANULARITY),
    .ADDR_BITS  (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_we    (w_mem_we),
    .i_be    (r_sel),
    .i_wdata (r_wdat),
    .o_rdata (w_rdata)
  );

  assign wb_ack_o = w_resp && !r_bad;
  assign wb_err_o = w_resp && r_bad;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = w_read_done ? w_rdata : r_dat_hold;

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_responder.sv
// ---------------------------------------------------------------------------
// | tb_wb_mem_responder : directed self-checking bench, four responders with |
// |                       0/1/3/15 wait states on private buses              |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_mem_responder;

  localparam int NI = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  adr  [NI];
  logic [127:0] wdat [NI];
  logic [127:0] rdat [NI];
  logic [15:0]  sel  [NI];
  logic         we   [NI];
  logic         stb  [NI];
  logic         cyc  [NI];
  logic         ack  [NI];
  logic         err  [NI];
  logic         rty  [NI];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] P1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] P2 = 128'hDEADBEEF00112233445566778899AABB;
  localparam logic [127:0] P3 = 128'h33333333_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] P4 = 128'h44444444_44444444_44444444_44444444;
  localparam logic [127:0] P5 = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
  localparam logic [127:0] P6 = 128'h66660000_11112222_33334444_55556666;
  localparam logic [127:0] P7 = 128'h77777777_00000000_77777777_00000001;
  localparam logic [127:0] P8 = 128'h88888888_99999999_AAAAAAAA_BBBBBBBB;

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wb_mem_responder #(
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .wb_adr_i (adr[g]),
      .wb_dat_i (wdat[g]),
      .wb_dat_o (rdat[g]),
      .wb_we_i  (we[g]),
      .wb_sel_i (sel[g]),
      .wb_stb_i (stb[g]),
      .wb_cyc_i (cyc[g]),
      .wb_ack_o (ack[g]),
      .wb_err_o (err[g]),
      .wb_rty_o (rty[g])
    );
  end

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one classic cycle; lat = edges from accept edge to the edge sampling termination.
  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [127:0] d,
                      input logic [15:0] s, output int lat, output logic got_ack,
                      output logic got_err, output logic [127:0] rd);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; wdat[k] = d; sel[k] = s;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      #1;
      if (ack[k] || err[k]) begin
        lat = n; got_ack = ack[k]; got_err = err[k]; rd = rdat[k];
        break;
      end
      @(posedge clk);
    end
    if (lat != 0) @(posedge clk);
    #1;
    cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
  endtask

  task automatic do_wr(input string tag, input int k, input logic [31:0] a,
                       input logic [127:0] d, input logic [15:0] s, input int exp_lat);
    int lat; logic ga, ge; logic [127:0] rd_unused;
    xfer(k, 1'b1, a, d, s, lat, ga, ge, rd_unused);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_ack"}, {ga, ge}, 2'b10);
  endtask

  task automatic do_rd(input string tag, input int k, input logic [31:0] a,
                       input logic [127:0] exp_d, input int exp_lat);
    int lat; logic ga, ge; logic [127:0] rd;
    xfer(k, 1'b0, a, '0, 16'hFFFF, lat, ga, ge, rd);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_ack"}, {ga, ge}, 2'b10);
    chk({tag, "_dat"}, rd, exp_d);
  endtask

  task automatic no_term(input string tag, input int k, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      if (ack[k] || err[k]) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk(tag, seen, 1'b0);
  endtask

  initial begin
    int lat; logic ga, ge; logic [127:0] rd;
    for (int k = 0; k < NI; k++) begin
      adr[k] = '0; wdat[k] = '0; sel[k] = '0; we[k] = 1'b0; stb[k] = 1'b0; cyc[k] = 1'b0;
    end

    #7;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_out%0d", k), {ack[k], err[k], rty[k], rdat[k]}, '0);
    end
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // basic write/read, one wait state
    do_wr("wr40", 1, 32'h40, P1, 16'hFFFF, 2);
    do_rd("rd40", 1, 32'h40, P1, 2);

    // byte lanes, zero select, low address bits ignored, output hold
    do_wr("clr80",  1, 32'h80, '0, 16'hFFFF, 2);
    do_wr("lane80", 1, 32'h80, {128{1'b1}}, 16'h0003, 2);
    do_rd("rd80",   1, 32'h80, 128'h0000FFFF, 2);
    do_wr("sel0",   1, 32'h84, {32{4'hA}}, 16'h0000, 2);
    do_rd("rd80b",  1, 32'h8F, 128'h0000FFFF, 2);
    do_wr("wrC0",   1, 32'hC0, P2, 16'hFFFF, 2);
    chk("hold_after_wr", rdat[1], 128'h0000FFFF);
    do_rd("rdC0",   1, 32'hC0, P2, 2);

    // abort in WAIT with three wait states
    do_wr("pre200", 2, 32'h200, P3, 16'hFFFF, 4);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h200; wdat[2] = P4; sel[2] = 16'hFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    no_term("abort_noterm", 2, 8);
    do_rd("post_abort", 2, 32'h200, P3, 4);

    // reset in the middle of a WAIT
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h200; wdat[2] = P5; sel[2] = 16'hFFFF;
    @(posedge clk); #2;
    chk("hold_pre_rst", rdat[2], P3);
    rst = 1'b1;
    #1;
    chk("rst_mid_wait", {ack[2], err[2], rdat[2]}, '0);
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    no_term("rst_noterm", 2, 8);
    do_rd("post_rst", 2, 32'h200, P3, 4);
    do_rd("keep40",   1, 32'h40, P1, 2);

    // latency sweep
    do_wr("w0_wr", 0, 32'h300, P6, 16'hFFFF, 1);
    do_rd("w0_rd", 0, 32'h300, P6, 1);
    do_wr("w15_wr", 3, 32'h310, P2, 16'hFFFF, 16);
    do_rd("w15_rd", 3, 32'h310, P2, 16);

    // upper address bits
    do_wr("line0_wr", 1, 32'h0, P7, 16'hFFFF, 2);
    do_rd("line0_rd", 1, 32'h0, P7, 2);
`ifdef WB_RESPONDER_RANGE_CHECK_EN
    xfer(1, 1'b1, 32'h8000_0000, P8, 16'hFFFF, lat, ga, ge, rd);
    chk("range_wr_lat", lat, 2);
    chk("range_wr_term", {ga, ge}, 2'b01);
    xfer(1, 1'b0, 32'h8000_0000, '0, 16'hFFFF, lat, ga, ge, rd);
    chk("range_rd_term", {ga, ge}, 2'b01);
    chk("range_rd_dat", rd, P7);
    no_term("range_single", 1, 2);
    do_rd("line0_keep", 1, 32'h0, P7, 2);
`else
    xfer(1, 1'b1, 32'h8000_0000, P8, 16'hFFFF, lat, ga, ge, rd);
    chk("alias_wr_lat", lat, 2);
    chk("alias_wr_term", {ga, ge}, 2'b10);
    chk("alias_wr_dat", rd, P7);
    do_rd("alias_rd", 1, 32'h0, P8, 2);
`endif
    chk("rty_tied", {rty[0], rty[1], rty[2], rty[3]}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
